// File: rtl/hazard_controller_if.sv
// Pipeline hazard inputs and stall/flush controls exchanged between the core datapath
// (master) and the hazard controller (slave).
interface hazard_controller_if;
  logic        hzd_exe_to_id_A;
  logic        exe_is_div;
  logic        exe_branch_taken;
  logic        mem_dc_req;
  logic        dc_ready;
  logic        stall_if;
  logic        stall_id;
  logic        stall_exe;
  logic        stall_mem;
  logic        flush_id;
  logic        flush_exe;
  logic        flush_mem;
  logic        flush_wb;
  logic        div_done;
  logic [31:0] stall_cnt;

  modport master (
    output hzd_exe_to_id_A, exe_is_div, exe_branch_taken, mem_dc_req, dc_ready,
    input  stall_if, stall_id, stall_exe, stall_mem,
    input  flush_id, flush_exe, flush_mem, flush_wb, div_done, stall_cnt
  );

  modport slave (
    input  hzd_exe_to_id_A, exe_is_div, exe_branch_taken, mem_dc_req, dc_ready,
    output stall_if, stall_id, stall_exe, stall_mem,
    output flush_id, flush_exe, flush_mem, flush_wb, div_done, stall_cnt
  );
endinterface

// File: rtl/hazard_controller.sv
// Stall/flush controller for the 5-stage core: cache-miss freeze, divider occupancy,
// branch squash and load-use bubble, plus a free-running stall-cycle counter.
//
// state    | meaning
// RUN      | normal flow; a divide arriving in EXE is stalled and starts the wait
// DIV_WAIT | divide occupies EXE; release (div_done) when div_cnt reaches 0 with no cache miss
module hazard_controller #(
  parameter int unsigned DIV_CYCLES = 33
) (
  input  logic               clk,
  input  logic               nrst,
  hazard_controller_if.slave hz
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {RUN, DIV_WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [31:0]      stall_cnt_q;

  logic dc_wait;
  logic stall_if, stall_id, stall_exe, stall_mem;
  logic flush_id, flush_exe, flush_mem, flush_wb, div_done;

  assign dc_wait = hz.mem_dc_req & ~hz.dc_ready;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= RUN;
      div_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      if (hz.stall_if) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_exe = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_exe = 1'b0;
    flush_mem = 1'b0;
    flush_wb  = 1'b0;
    div_done  = 1'b0;

    case (state_q)
      RUN: begin
        if (hz.exe_is_div && !dc_wait) begin
          state_d   = DIV_WAIT;
          div_cnt_d = CNT_LOAD;
        end
      end
      DIV_WAIT: begin
        // The divider keeps counting even while MEM is frozen on a miss.
        if (div_cnt_q != '0) begin
          div_cnt_d = div_cnt_q - CNT_W'(1);
        end else if (!dc_wait) begin
          state_d  = RUN;
          div_done = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (dc_wait) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_exe = 1'b1;
      stall_mem = 1'b1;
      flush_wb  = 1'b1;
    end else if ((state_q == DIV_WAIT && div_cnt_q != '0) ||
                 (state_q == RUN && hz.exe_is_div)) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_exe = 1'b1;
      flush_mem = 1'b1;
    end else if (hz.exe_branch_taken) begin
      flush_id  = 1'b1;
      flush_exe = 1'b1;
    end else if (hz.hzd_exe_to_id_A) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      flush_exe = 1'b1;
    end
  end

  // Reset holds every control low regardless of what the pipeline presents.
  assign hz.stall_if  = stall_if  & nrst;
  assign hz.stall_id  = stall_id  & nrst;
  assign hz.stall_exe = stall_exe & nrst;
  assign hz.stall_mem = stall_mem & nrst;
  assign hz.flush_id  = flush_id  & nrst;
  assign hz.flush_exe = flush_exe & nrst;
  assign hz.flush_mem = flush_mem & nrst;
  assign hz.flush_wb  = flush_wb  & nrst;
  assign hz.div_done  = div_done  & nrst;
  assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline stall/flush controller for the 5-stage RV32IMC core. Consumes the load-use hazard flag from the forwarding unit, the multi-cycle divider occupancy in EXE, data-cache miss status in MEM and branch/jump redirects resolved in EXE. Produces per-stage hold (stall) and bubble (flush) controls for the PC and the IF/ID, ID/EXE, EXE/MEM and MEM/WB registers. Also keeps a free-running stall-cycle performance counter.

## Interface
- DIV_CYCLES, 33, number of cycles a divide occupies EXE before its result is valid (legal range 1..255)
- clk  in  1  core clock, all state on rising edge
- nrst  in  1  asynchronous active-low reset
- hzd_exe_to_id_A  in  1  load in EXE feeds JALR base in ID (from forwarding unit)
- exe_is_div  in  1  EXE holds DIV/DIVU/REM/REMU
- exe_branch_taken  in  1  EXE resolved a taken branch or JAL/JALR redirect
- mem_dc_req  in  1  MEM holds a load/store accessing the data cache
- dc_ready  in  1  data cache has completed the MEM access this cycle
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID
- stall_exe  out  1  hold ID/EXE
- stall_mem  out  1  hold EXE/MEM
- flush_id  out  1  load NOP into IF/ID
- flush_exe  out  1  load NOP into ID/EXE
- flush_mem  out  1  load NOP into EXE/MEM
- flush_wb  out  1  load NOP into MEM/WB
- div_done  out  1  one-cycle pulse: divide result valid, div leaves EXE this cycle
- stall_cnt  out  32  count of cycles with stall_if=1

## Operation
- FSM states: RUN, DIV_WAIT. Down-counter div_cnt, width $clog2(DIV_CYCLES+1).
- dc_wait = mem_dc_req & !dc_ready.
- Outputs are combinational from state and inputs, evaluated in strict priority. Unlisted outputs are 0:
  1. dc_wait: stall_if, stall_id, stall_exe, stall_mem = 1; flush_wb = 1.
  2. state DIV_WAIT & div_cnt != 0, or state DIV_WAIT & div_cnt == 0 & dc_wait (already covered by 1), or state RUN & exe_is_div: stall_if, stall_id, stall_exe = 1; flush_mem = 1.
  3. exe_branch_taken: flush_id, flush_exe = 1. A load-use hazard in ID is ignored because that instruction is squashed.
  4. hzd_exe_to_id_A: stall_if, stall_id = 1; flush_exe = 1. Exactly one bubble; the load then sits in MEM, where the datapath forwards it.
- Transitions:
  - RUN -> DIV_WAIT when exe_is_div & !dc_wait; load div_cnt = DIV_CYCLES-1.
  - DIV_WAIT: div_cnt decrements when nonzero, including during dc_wait.
  - DIV_WAIT -> RUN when div_cnt == 0 & !dc_wait. That cycle is the release cycle: no stall, div_done = 1.
  - Entering DIV_WAIT is blocked while dc_wait; the div re-evaluates every cycle.
- A divide therefore stalls exactly DIV_CYCLES cycles when there are no cache misses, followed by one release cycle.
- Back-to-back divides: the release cycle returns to RUN. The next div arriving in EXE starts a fresh wait.
- exe_is_div, exe_branch_taken and hzd_exe_to_id_A are mutually exclusive by ISA/decode, except branch with hzd (handled by priority 3).
- stall_cnt increments by 1 on every clock with stall_if = 1 and wraps modulo 2^32.

## Timing
- Reset (nrst low, asynchronous):
  - state = RUN, div_cnt = 0, stall_cnt = 0.
  - All stall/flush outputs and div_done are forced to 0 regardless of inputs.
- On nrst deassertion, operation resumes from RUN on the next edge.
- Input-to-output path is purely combinational, zero latency. State updates at the rising edge.
- Reset mid-divide abandons the wait; the divide is not resumed.
- dc_ready may rise in any cycle. The freeze ends in that same cycle (stalls drop combinationally).

## Test plan
- Load-use JALR: hzd_exe_to_id_A=1 for one cycle -> stall_if=stall_id=flush_exe=1 for that cycle only, stall_cnt +1.
- Divide, DIV_CYCLES=4, exe_is_div held until div_done: stall_if/id/exe and flush_mem high for exactly 4 cycles, then div_done=1 with no stalls on cycle 5; stall_cnt +4.
- Cache miss during divide, DIV_CYCLES=4: mem_dc_req=1, dc_ready=0 from cycle 2 to cycle 7.
  - stall_mem and flush_wb are high on cycles 2-7.
  - div_done does not fire until cycle 8, and stall_cnt=7 after it.
- Branch vs load-use: exe_branch_taken=1 and hzd_exe_to_id_A=1 in the same cycle -> flush_id=flush_exe=1, stall_if=0.
- Cache miss blocks branch flush: dc_wait with exe_branch_taken=1 for 3 cycles, then dc_ready=1 -> no flush while frozen, flush_id=flush_exe=1 on the release cycle.
- Asynchronous reset asserted at div_cnt=2 -> all outputs 0 immediately. After release, an exe_is_div starts a full DIV_CYCLES wait and stall_cnt counts from 0.
